apb_master_bridge: RTL

- Upstream APB requester for the 8-bit APB slave RAM and other APB slaves on the same bus.
- Accepts single read/write commands on a valid/ready request port and runs the two-phase APB transfer (SETUP, then ACCESS).
- Waits for pready and returns read data or an error on a one-cycle response strobe.
- A watchdog aborts ACCESS phases that receive no pready within a bound.

---
 rtl/apb_pkg.sv | 21 ++
 rtl/apb_watchdog.sv | 29 ++
 rtl/apb_master_bridge.sv | 124 ++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB master bridge.
package apb_pkg;

  localparam int unsigned APB_ADDR_W = 8;
  localparam int unsigned APB_DATA_W = 8;

  // Bridge FSM: IDLE accepts, SETUP drives psel alone, ACCESS waits for pready.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_mst_state_t;

  // One command as presented on the request port (default widths).
  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

endpackage

// File: rtl/apb_watchdog.sv
// ACCESS-phase watchdog: counts stalled cycles and flags the last permitted one.
module apb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int unsigned     CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  // Value seen on the final stalled ACCESS cycle; meaningless when the watchdog is disabled.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  // Clear on reset or new transfer; count stalled cycles, saturating at all-ones.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expire = (TIMEOUT_CYCLES != 0) && (r_cnt == LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB requester: valid/ready command in, SETUP/ACCESS transfer out,
// one-cycle response strobe back, with a watchdog abort for slaves that never ready.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W         = APB_ADDR_W,
  parameter int unsigned DATA_W         = APB_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata
);

  apb_mst_state_t    r_state;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;

  logic w_accept;
  logic w_wd_en;
  logic w_expire;

  // Ready is forced low while reset is asserted so nothing is accepted into a resetting FSM.
  always_comb begin
    req_ready = (r_state == IDLE) && !preset;
    w_accept  = req_valid && req_ready;
    w_wd_en   = (r_state == ACCESS) && !pready;
  end

  apb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk    (pclk),
    .i_rst    (preset),
    .i_clr    (w_accept),
    .i_en     (w_wd_en),
    .o_expire (w_expire)
  );

  // Transfer FSM with registered APB and response outputs.
  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state     <= IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_pwrite <= req_write;
            r_paddr  <= req_addr;
            r_pwdata <= req_wdata;
            r_psel   <= 1'b1;
            r_state  <= SETUP;
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          // pready is checked first so a completion on the expiry cycle still succeeds.
          if (pready) begin
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= r_pwrite ? '0 : prdata;
            r_rsp_err   <= 1'b0;
            r_state     <= IDLE;
          end else if (w_expire) begin
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule
